apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, APB address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum number of ACCESS cycles with pready low before the transfer is aborted; legal range 2..255.
REQ-004 pclk  in  1  single clock; all state updates on the rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous and active-low.
REQ-006 cmd_valid  in  1  request offered.
REQ-007 cmd_ready  out  1  request accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-013 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers.
REQ-014 rsp_err  out  1  1 = transfer aborted by timeout.
REQ-015 paddr, pwrite, psel, penable, pwdata  out  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB requester outputs.
REQ-016 prdata, pready  in  DATA_WIDTH/1  APB completer inputs.

Function
REQ-017 The block SHALL implement exactly four states: IDLE, SETUP, ACCESS, RESP. All outputs SHALL be registered or decoded from state only, never combinationally from inputs.
REQ-018 IDLE: cmd_ready=1, psel=0, penable=0. On a cmd handshake, the block SHALL capture cmd_write, cmd_addr and cmd_wdata into paddr/pwrite/pwdata and go to SETUP.
REQ-019 SETUP: psel=1, penable=0, cmd_ready=0. The state SHALL last exactly one cycle, then go to ACCESS.
REQ-020 ACCESS: psel=1, penable=1. paddr, pwrite and pwdata SHALL be held stable from SETUP until the transfer ends.
REQ-021 ACCESS with pready=1 at a rising edge: the transfer SHALL complete and the state SHALL go to RESP.
  - For reads, rsp_rdata SHALL be loaded with prdata sampled at that edge.
  - For writes, rsp_rdata SHALL be 0.
  - rsp_err SHALL be 0.
REQ-022 Wait-state counter:
  - SHALL clear on entry to ACCESS.
  - SHALL increment on each ACCESS edge with pready=0.
  - When it reaches TIMEOUT_CYCLES, the state SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
  - pready arriving on that same edge SHALL take priority, and the transfer SHALL complete normally.
REQ-023 RESP: psel=0, penable=0, rsp_valid=1, cmd_ready=0. rsp_rdata and rsp_err SHALL be held until the rsp handshake, then the state SHALL go to IDLE.
REQ-024 Minimum latency from cmd handshake edge to rsp_valid high is 3 cycles (zero wait states). With N wait states it is 3+N cycles. Minimum cmd-to-cmd spacing is 4 cycles.
REQ-025 psel SHALL be high only in SETUP and ACCESS. penable SHALL be high only in ACCESS. penable SHALL never rise without a preceding SETUP cycle.
REQ-026 cmd_valid changes outside IDLE SHALL be ignored. pready and prdata outside ACCESS SHALL be ignored.
REQ-027 rsp_ready held high in RESP SHALL complete the handshake on the first RESP edge.

Reset
REQ-028 PRESETn low SHALL immediately force, regardless of pclk:
  - state=IDLE, wait-state counter=0;
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - cmd_ready=1 after reset release.
REQ-029 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abort the transfer with no response generated. The first cmd accepted after reset SHALL start a fresh SETUP.

Verification
REQ-030 Write, zero wait, completer tied to 1024x32 APB memory: cmd write addr 0x3FF data 0xDEADBEEF -> one SETUP then one ACCESS with paddr=0x3FF, pwdata=0xDEADBEEF; rsp_valid 3 cycles after the cmd handshake; rsp_err=0; rsp_rdata=0.
REQ-031 Read-back: cmd read addr 0x3FF after REQ-030 -> rsp_rdata=0xDEADBEEF, rsp_err=0; psel/penable pattern 1/0 then 1/1 then 0/0.
REQ-032 Wait states: pready held low for 5 ACCESS cycles, read prdata=0x12345678 on the 6th -> penable high 6 cycles, paddr stable throughout, rsp_valid at cycle 8, rsp_rdata=0x12345678.
REQ-033 Timeout: pready held at 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0. Variant with pready=1 on the 16th edge -> normal completion, rsp_err=0.
REQ-034 Backpressure: rsp_ready low for 10 cycles -> rsp_valid and data held stable, cmd_ready=0 and cmd_valid ignored; after the handshake, cmd_ready=1 next cycle.
REQ-035 Reset mid-ACCESS: PRESETn low during the 2nd wait cycle -> psel, penable and rsp_valid go to 0 immediately; after release, a new read of addr 0x001 completes normally with 3-cycle latency.

Source files
------------

// File: rtl/apb_master_if.sv
// Signal bundle for apb_master: command in, response out, APB requester/completer pins.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes; pready stretches APB ACCESS.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // APB bus
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    // view of the block that issues APB transfers
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready
    );

    // view of the surrounding environment (command source, response sink, completer)
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns one command into one SETUP/ACCESS transfer and one response.
// Latency: response valid 3 cycles after the command handshake, plus one per wait state; aborts after TIMEOUT_CYCLES.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready, no new command until then.
module apb_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         pclk,
    input  logic         PRESETn,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Last wait-state count value: an ACCESS edge with pready low at this count ends the transfer.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;

    logic [7:0]            wait_cnt;
    logic                  wait_last;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  cmd_take;
    logic                  xfer_done;

    // A command is only ever taken in IDLE; cmd_valid is don't-care elsewhere.
    assign cmd_take  = (state == IDLE) && bus.cmd_valid;
    // pready only matters in ACCESS; outside it the completer is ignored.
    assign xfer_done = (state == ACCESS) && bus.pready;
    assign wait_last = (wait_cnt == WAIT_LAST);

    // State register; reset drops any transfer in flight without a response.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus all handshake/strobe outputs, decoded from the current state only.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.psel      = 1'b0;
        bus.penable   = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                bus.psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                // pready wins over the timeout when both land on the same edge
                if (bus.pready || wait_last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the command; these registers drive the APB address/data and stay frozen until the next command.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (cmd_take) begin
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
        end
    end

    // Wait-state counter: zeroed in SETUP so every ACCESS starts from 0, counts edges with pready low.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Response payload: loaded when ACCESS ends, untouched through RESP so it is held under backpressure.
    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (xfer_done) begin
            rdata_q <= pwrite_q ? '0 : bus.prdata;
            err_q   <= 1'b0;
        end else if ((state == ACCESS) && wait_last) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // penable is never seen without psel
    a_pen_needs_sel: assert property (@(posedge pclk) disable iff (!PRESETn)
        bus.penable |-> bus.psel);

    // every ACCESS is entered from SETUP
    a_access_after_setup: assert property (@(posedge pclk) disable iff (!PRESETn)
        (state_nxt == ACCESS) |-> (state == SETUP || state == ACCESS));

    // address/control/write data do not move while the transfer is on the bus
    a_req_stable: assert property (@(posedge pclk) disable iff (!PRESETn)
        (state == ACCESS) |-> ($stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q)));

    // the wait counter can never run past the abort point
    a_wait_bound: assert property (@(posedge pclk) disable iff (!PRESETn)
        (state == ACCESS) |-> (wait_cnt <= WAIT_LAST));

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a 1024x32 APB memory completer with programmable wait states.
// Latency: cycle 1 is the cycle right after the command handshake edge.
// Backpressure: rsp_ready is driven per scenario to exercise held responses.
module tb_apb_master;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic pclk = 1'b0;
    logic PRESETn;
    always #5 pclk = ~pclk;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk    (pclk),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // completer: memory plus wait-state control
    logic [DW-1:0] mem [0:1023];
    int            acc_cnt       = 0;
    int            cfg_waits     = 0;
    bit            cfg_never     = 1'b0;
    bit            cfg_always    = 1'b0;
    bit            cfg_fixed     = 1'b0;
    logic [DW-1:0] cfg_fixed_dat = '0;

    always_comb begin
        bus.pready = 1'b0;
        if (cfg_always) bus.pready = 1'b1;
        else if (bus.psel && bus.penable && !cfg_never && acc_cnt >= cfg_waits) bus.pready = 1'b1;
        bus.prdata = cfg_fixed ? cfg_fixed_dat : mem[bus.paddr];
    end

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && bus.pready && bus.pwrite) mem[bus.paddr] <= bus.pwdata;
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // bus protocol monitor
    logic          prev_psel  = 1'b0;
    logic          prev_pen   = 1'b0;
    logic          prev_wr    = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_wdat  = '0;

    always @(negedge pclk) begin
        if (PRESETn) begin
            if (bus.penable && !prev_pen) begin
                checks++;
                if (!(bus.psel && prev_psel)) begin
                    errors++;
                    $display("FAIL mon_setup_first: psel=%b prev_psel=%b, required both 1", bus.psel, prev_psel);
                end
            end
            if (bus.psel && prev_psel) begin
                checks++;
                if ({bus.paddr, bus.pwrite, bus.pwdata} !== {prev_addr, prev_wr, prev_wdat}) begin
                    errors++;
                    $display("FAIL mon_stable: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                             bus.paddr, bus.pwrite, bus.pwdata, prev_addr, prev_wr, prev_wdat);
                end
            end
        end
        prev_psel <= bus.psel;
        prev_pen  <= bus.penable;
        prev_wr   <= bus.pwrite;
        prev_addr <= bus.paddr;
        prev_wdat <= bus.pwdata;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // waits (bounded) for IDLE, then presents one command for a single handshake edge
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        checks++; if ({bus.psel, bus.penable} !== 2'b00) begin errors++; $display("FAIL reset_sel_en: got %b want 00", {bus.psel, bus.penable}); end
        checks++; if ({bus.pwrite, bus.paddr} !== {1'b0, 10'h000}) begin errors++; $display("FAIL reset_addr: got wr=%b addr=%h want 0/000", bus.pwrite, bus.paddr); end
        checks++; if (bus.pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata: got %h want 0", bus.pwdata); end
        checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", {bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
        repeat (3) @(posedge pclk);
        @(negedge pclk) PRESETn = 1'b1;
        tick();
        checks++; if ({bus.cmd_ready, bus.psel} !== 2'b10) begin errors++; $display("FAIL reset_release: cmd_ready/psel got %b want 10", {bus.cmd_ready, bus.psel}); end
    endtask

    // zero-wait write; completer holds pready high everywhere, which only counts in ACCESS
    task automatic test_write();
        cfg_always = 1'b1;
        bus.rsp_ready = 1'b0;
        issue(1'b1, 10'h3FF, 32'hDEADBEEF);
        checks++; if ({bus.psel, bus.penable, bus.pwrite, bus.cmd_ready, bus.rsp_valid} !== 5'b10100) begin errors++; $display("FAIL wr_setup: sel/en/wr/crdy/rvld got %b want 10100", {bus.psel, bus.penable, bus.pwrite, bus.cmd_ready, bus.rsp_valid}); end
        checks++; if ({bus.paddr, bus.pwdata} !== {10'h3FF, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_setup_bus: got %h/%h want 3ff/deadbeef", bus.paddr, bus.pwdata); end
        tick();
        checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin errors++; $display("FAIL wr_access: got %b want 110", {bus.psel, bus.penable, bus.rsp_valid}); end
        tick();
        checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err} !== 5'b00100) begin errors++; $display("FAIL wr_resp: sel/en/rvld/crdy/err got %b want 00100", {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.rsp_err}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (mem[10'h3FF] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem: got %h want deadbeef", mem[10'h3FF]); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        cfg_always = 1'b0;
        checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr_idle: rvld/crdy got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    endtask

    // read-back with rsp_ready already high: handshake on the first RESP edge
    task automatic test_read_back();
        cfg_waits = 0;
        bus.rsp_ready = 1'b1;
        issue(1'b0, 10'h3FF, 32'h11111111);
        checks++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100) begin errors++; $display("FAIL rd_setup: got %b want 100", {bus.psel, bus.penable, bus.pwrite}); end
        tick();
        checks++; if ({bus.psel, bus.penable} !== 2'b11) begin errors++; $display("FAIL rd_access: got %b want 11", {bus.psel, bus.penable}); end
        tick();
        checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err} !== 4'b0010) begin errors++; $display("FAIL rd_resp: got %b want 0010", {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", bus.rsp_rdata); end
        tick();
        checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL rd_first_edge: rvld/crdy got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        int pen_cycles;
        int rsp_cycle;
        bit addr_ok;
        pen_cycles = 0; rsp_cycle = 0; addr_ok = 1'b1;
        cfg_waits = 5; cfg_fixed = 1'b1; cfg_fixed_dat = 32'h12345678;
        issue(1'b0, 10'h055, 32'h0);
        for (int c = 1; c <= 12 && rsp_cycle == 0; c++) begin
            if (bus.penable) pen_cycles++;
            if (bus.psel && bus.paddr !== 10'h055) addr_ok = 1'b0;
            if (bus.rsp_valid) rsp_cycle = c;
            else tick();
        end
        checks++; if (pen_cycles !== 6) begin errors++; $display("FAIL ws_penable: got %0d cycles want 6", pen_cycles); end
        checks++; if (rsp_cycle !== 8) begin errors++; $display("FAIL ws_latency: got cycle %0d want 8", rsp_cycle); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL ws_addr: paddr moved, got ok=%b want 1", addr_ok); end
        checks++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL ws_rdata: got err=%b %h want 0/12345678", bus.rsp_err, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int pen_cycles;
        int rsp_cycle;
        cfg_fixed = 1'b1; cfg_fixed_dat = 32'hA5A5A5A5;
        // pready never comes: abort after exactly 16 ACCESS cycles
        cfg_never = 1'b1;
        pen_cycles = 0; rsp_cycle = 0;
        issue(1'b0, 10'h010, 32'h0);
        for (int c = 1; c <= 30 && rsp_cycle == 0; c++) begin
            if (bus.penable) pen_cycles++;
            if (bus.rsp_valid) rsp_cycle = c;
            else tick();
        end
        checks++; if (pen_cycles !== 16) begin errors++; $display("FAIL to_penable: got %0d cycles want 16", pen_cycles); end
        checks++; if (rsp_cycle !== 18) begin errors++; $display("FAIL to_latency: got cycle %0d want 18", rsp_cycle); end
        checks++; if ({bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b011, 32'h0}) begin errors++; $display("FAIL to_resp: sel/rvld/err got %b rdata %h want 011/0", {bus.psel, bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
        // pready arrives on the 16th ACCESS edge: normal completion wins
        cfg_never = 1'b0; cfg_waits = 15;
        pen_cycles = 0; rsp_cycle = 0;
        issue(1'b0, 10'h010, 32'h0);
        for (int c = 1; c <= 30 && rsp_cycle == 0; c++) begin
            if (bus.penable) pen_cycles++;
            if (bus.rsp_valid) rsp_cycle = c;
            else tick();
        end
        checks++; if ({pen_cycles, rsp_cycle} !== {32'd16, 32'd18}) begin errors++; $display("FAIL to_edge_timing: got pen=%0d rsp=%0d want 16/18", pen_cycles, rsp_cycle); end
        checks++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b0, 32'hA5A5A5A5}) begin errors++; $display("FAIL to_edge_resp: got err=%b %h want 0/a5a5a5a5", bus.rsp_err, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
        cfg_fixed = 1'b0; cfg_waits = 0;
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 10'h3FF, 32'h0);
        tick(); tick();
        // park a competing command while the response is stalled
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 10'h2AA; bus.cmd_wdata = 32'h00000055;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.psel, bus.rsp_err, bus.rsp_rdata} !== {4'b1000, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rvld/crdy/sel/err got %b rdata %h want 1000/deadbeef", i,
                         {bus.rsp_valid, bus.cmd_ready, bus.psel, bus.rsp_err}, bus.rsp_rdata);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
        checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.psel} !== 3'b100) begin errors++; $display("FAIL bp_release: crdy/rvld/sel got %b want 100", {bus.cmd_ready, bus.rsp_valid, bus.psel}); end
    endtask

    // cmd_valid held high across two commands: second is taken 4 edges after the first
    task automatic test_back_to_back();
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 10'h001; bus.cmd_wdata = 32'hCAFE0001;
        tick();
        bus.cmd_addr = 10'h002; bus.cmd_wdata = 32'hCAFE0002;
        tick();
        checks++; if ({bus.penable, bus.paddr, bus.pwdata} !== {1'b1, 10'h001, 32'hCAFE0001}) begin errors++; $display("FAIL b2b_first_held: en=%b addr=%h wdata=%h want 1/001/cafe0001", bus.penable, bus.paddr, bus.pwdata); end
        tick(); tick();
        checks++; if ({bus.cmd_ready, bus.psel} !== 2'b10) begin errors++; $display("FAIL b2b_idle: crdy/sel got %b want 10", {bus.cmd_ready, bus.psel}); end
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if ({bus.psel, bus.penable, bus.paddr, bus.pwdata} !== {2'b10, 10'h002, 32'hCAFE0002}) begin errors++; $display("FAIL b2b_second: sel/en=%b addr=%h wdata=%h want 10/002/cafe0002", {bus.psel, bus.penable}, bus.paddr, bus.pwdata); end
        tick(); tick(); tick();
        bus.rsp_ready = 1'b0;
        checks++; if ({mem[1], mem[2]} !== {32'hCAFE0001, 32'hCAFE0002}) begin errors++; $display("FAIL b2b_mem: got %h %h want cafe0001 cafe0002", mem[1], mem[2]); end
    endtask

    task automatic test_reset_mid_access();
        cfg_never = 1'b1;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 10'h3FF, 32'h0);
        tick(); tick();
        checks++; if ({bus.psel, bus.penable} !== 2'b11) begin errors++; $display("FAIL rst_pre: sel/en got %b want 11", {bus.psel, bus.penable}); end
        #2 PRESETn = 1'b0;
        #1;
        checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.paddr} !== {3'b000, 10'h000}) begin errors++; $display("FAIL rst_async: sel/en/rvld got %b addr %h want 000/000", {bus.psel, bus.penable, bus.rsp_valid}, bus.paddr); end
        repeat (2) @(posedge pclk);
        @(negedge pclk) PRESETn = 1'b1;
        cfg_never = 1'b0; cfg_waits = 0;
        tick();
        checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL rst_no_rsp: rvld/crdy got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
        issue(1'b0, 10'h001, 32'h0);
        checks++; if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 10'h001}) begin errors++; $display("FAIL rst_fresh_setup: sel/en=%b addr=%h want 10/001", {bus.psel, bus.penable}, bus.paddr); end
        tick(); tick();
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'hCAFE0001}) begin errors++; $display("FAIL rst_after_read: rvld/err=%b rdata=%h want 10/cafe0001", {bus.rsp_valid, bus.rsp_err}, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_back();
        test_wait_states();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
